// File: rtl/fp_special_case_unit.sv
// ============================================================================
// Module      : fp_special_case_unit
// Description : Two-stage elastic IEEE-754 special-case resolver for the
//               multiply / divide datapath. Classifies both raw operands,
//               resolves NaN / Inf / zero outcomes, raises per-result and
//               sticky invalid / divide-by-zero flags.
//               Optional build macro: FP_SPECIAL_DENORM_FLUSH_EN
//               (subnormal operands are classified as zero).
// Revision    : 1.0 - initial parametrised, pipelined release
// ============================================================================
`default_nettype none

module fp_special_case_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op_div,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     special_result,
    output logic                     is_special,
    output logic                     flag_invalid,
    output logic                     flag_dbz,
    output logic                     sticky_invalid,
    output logic                     sticky_dbz,
    input  logic                     flags_clr
);

    localparam int               c_W        = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] c_EXP_ONES = '1;
    localparam logic [EXP_W-1:0] c_EXP_ZERO = '0;
    localparam logic [MAN_W-1:0] c_MAN_ZERO = '0;
    localparam logic [MAN_W-1:0] c_MAN_QNAN = {{(MAN_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Operand field extraction and classification (feeds S1 only)
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_man, w_b_man;
    logic             w_a_nan, w_a_inf, w_a_zero;
    logic             w_b_nan, w_b_inf, w_b_zero;

    assign w_a_exp = a[MAN_W +: EXP_W];
    assign w_b_exp = b[MAN_W +: EXP_W];
    assign w_a_man = a[MAN_W-1:0];
    assign w_b_man = b[MAN_W-1:0];

    assign w_a_nan = (w_a_exp == c_EXP_ONES) && (w_a_man != c_MAN_ZERO);
    assign w_b_nan = (w_b_exp == c_EXP_ONES) && (w_b_man != c_MAN_ZERO);
    assign w_a_inf = (w_a_exp == c_EXP_ONES) && (w_a_man == c_MAN_ZERO);
    assign w_b_inf = (w_b_exp == c_EXP_ONES) && (w_b_man == c_MAN_ZERO);

`ifdef FP_SPECIAL_DENORM_FLUSH_EN
    // Subnormals are treated as zero for every rule
    assign w_a_zero = (w_a_exp == c_EXP_ZERO);
    assign w_b_zero = (w_b_exp == c_EXP_ZERO);
`else
    // Subnormals remain finite nonzero values
    assign w_a_zero = (w_a_exp == c_EXP_ZERO) && (w_a_man == c_MAN_ZERO);
    assign w_b_zero = (w_b_exp == c_EXP_ZERO) && (w_b_man == c_MAN_ZERO);
`endif

    // ------------------------------------------------------------------
    // Elastic pipeline advance controls
    // ------------------------------------------------------------------
    logic r_s1_valid, r_s2_valid;
    logic w_s1_adv, w_s2_adv, w_out_hs;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_out_hs = r_s2_valid && out_ready;

    // ------------------------------------------------------------------
    // Stage 1 registers: classification bits, result sign, operation
    // ------------------------------------------------------------------
    logic r_s1_a_nan, r_s1_a_inf, r_s1_a_zero;
    logic r_s1_b_nan, r_s1_b_inf, r_s1_b_zero;
    logic r_s1_sign, r_s1_div;

    // S1 valid follows the input whenever the stage may advance; data loads only on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a_nan  <= 1'b0;
            r_s1_a_inf  <= 1'b0;
            r_s1_a_zero <= 1'b0;
            r_s1_b_nan  <= 1'b0;
            r_s1_b_inf  <= 1'b0;
            r_s1_b_zero <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_div    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a_nan  <= w_a_nan;
                r_s1_a_inf  <= w_a_inf;
                r_s1_a_zero <= w_a_zero;
                r_s1_b_nan  <= w_b_nan;
                r_s1_b_inf  <= w_b_inf;
                r_s1_b_zero <= w_b_zero;
                r_s1_sign   <= a[c_W-1] ^ b[c_W-1];
                r_s1_div    <= op_div;
            end
        end
    end

    // ------------------------------------------------------------------
    // Special-case resolution from S1 state (first matching rule wins)
    // ------------------------------------------------------------------
    logic [c_W-1:0] w_res;
    logic           w_special, w_invalid, w_dbz;
    logic [c_W-1:0] w_nan_val, w_inf_val, w_zero_val;

    assign w_nan_val  = {r_s1_sign, c_EXP_ONES, c_MAN_QNAN};
    assign w_inf_val  = {r_s1_sign, c_EXP_ONES, c_MAN_ZERO};
    assign w_zero_val = {r_s1_sign, c_EXP_ZERO, c_MAN_ZERO};

    // Priority-ordered rule table for multiply and divide
    always_comb begin
        w_res     = w_zero_val;
        w_special = 1'b0;
        w_invalid = 1'b0;
        w_dbz     = 1'b0;
        if (r_s1_a_nan || r_s1_b_nan) begin
            w_res     = w_nan_val;
            w_special = 1'b1;
        end else if (!r_s1_div) begin
            if ((r_s1_a_inf && r_s1_b_zero) || (r_s1_a_zero && r_s1_b_inf)) begin
                w_res     = w_nan_val;
                w_special = 1'b1;
                w_invalid = 1'b1;
            end else if (r_s1_a_inf || r_s1_b_inf) begin
                w_res     = w_inf_val;
                w_special = 1'b1;
            end else if (r_s1_a_zero || r_s1_b_zero) begin
                w_res     = w_zero_val;
                w_special = 1'b1;
            end
        end else begin
            if ((r_s1_a_zero && r_s1_b_zero) || (r_s1_a_inf && r_s1_b_inf)) begin
                w_res     = w_nan_val;
                w_special = 1'b1;
                w_invalid = 1'b1;
            end else if (r_s1_a_inf) begin
                w_res     = w_inf_val;
                w_special = 1'b1;
            end else if (r_s1_b_zero) begin
                // a is finite nonzero here: earlier rules removed NaN, Inf and 0/0
                w_res     = w_inf_val;
                w_special = 1'b1;
                w_dbz     = 1'b1;
            end else if (r_s1_b_inf || r_s1_a_zero) begin
                w_res     = w_zero_val;
                w_special = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: resolved result and per-result flags
    // ------------------------------------------------------------------
    logic [c_W-1:0] r_s2_result;
    logic           r_s2_special, r_s2_invalid, r_s2_dbz;

    // S2 loads from S1 when it may advance; outputs hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_result  <= '0;
            r_s2_special <= 1'b0;
            r_s2_invalid <= 1'b0;
            r_s2_dbz     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result  <= w_res;
                r_s2_special <= w_special;
                r_s2_invalid <= w_invalid;
                r_s2_dbz     <= w_dbz;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set on the output handshake beats a same-cycle clear
    // ------------------------------------------------------------------
    logic r_sticky_invalid, r_sticky_dbz;

    // Accumulate flags of results actually consumed downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_invalid <= 1'b0;
            r_sticky_dbz     <= 1'b0;
        end else begin
            r_sticky_invalid <= (flags_clr ? 1'b0 : r_sticky_invalid) | (w_out_hs & r_s2_invalid);
            r_sticky_dbz     <= (flags_clr ? 1'b0 : r_sticky_dbz)     | (w_out_hs & r_s2_dbz);
        end
    end

    assign out_valid      = r_s2_valid;
    assign special_result = r_s2_result;
    assign is_special     = r_s2_special;
    assign flag_invalid   = r_s2_invalid;
    assign flag_dbz       = r_s2_dbz;
    assign sticky_invalid = r_sticky_invalid;
    assign sticky_dbz     = r_sticky_dbz;

endmodule

`default_nettype wire

// File: tb/tb_fp_special_case_unit.sv
// ============================================================================
// Module      : tb_fp_special_case_unit
// Description : Scoreboard bench for fp_special_case_unit (default 32-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_special_case_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] special_result;
    logic        is_special;
    logic        flag_invalid;
    logic        flag_dbz;
    logic        sticky_invalid;
    logic        sticky_dbz;
    logic        flags_clr = 1'b0;

    fp_special_case_unit #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_div(op_div), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .special_result(special_result),
        .is_special(is_special), .flag_invalid(flag_invalid),
        .flag_dbz(flag_dbz), .sticky_invalid(sticky_invalid),
        .sticky_dbz(sticky_dbz), .flags_clr(flags_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        sp;
        logic        inv;
        logic        dbz;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Directed vector table with hand-computed expectations
    logic        v_op  [15];
    logic [31:0] v_a   [15];
    logic [31:0] v_b   [15];
    exp_t        v_exp [15];

    task automatic setv(input int i, input logic op, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] r, input logic sp, input logic inv, input logic dbz);
        v_op[i] = op; v_a[i] = va; v_b[i] = vb;
        v_exp[i] = '{res: r, sp: sp, inv: inv, dbz: dbz};
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference occupancy model of the two stage valid bits
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 <= 1'b0;
            m_s2 <= 1'b0;
        end else begin
            if (!m_s2 || out_ready) m_s2 <= m_s1;
            if (!m_s1 || !m_s2 || out_ready) m_s1 <= in_valid;
        end
    end

    // Monitor: handshake model, in-order scoreboard, stall stability via q[0]
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid_model", {31'b0, out_valid}, {31'b0, m_s2});
            chk("in_ready_model", {31'b0, in_ready}, {31'b0, (!m_s1 || !m_s2 || out_ready)});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("special_result", special_result, q[0].res);
                    chk("is_special", {31'b0, is_special}, {31'b0, q[0].sp});
                    chk("flag_invalid", {31'b0, flag_invalid}, {31'b0, q[0].inv});
                    chk("flag_dbz", {31'b0, flag_dbz}, {31'b0, q[0].dbz});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Offer one vector, hold until accepted, push its expectation on acceptance
    task automatic send(input int i);
        logic acc;
        int   n;
        in_valid = 1'b1; op_div = v_op[i]; a = v_a[i]; b = v_b[i];
        n = 0;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 32'd1, 32'd0);
        else q.push_back(v_exp[i]);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic clr_pulse();
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
    endtask

    logic [3:0] pat = 4'b1001;
    int         stream_ids [8] = '{0, 1, 2, 5, 9, 11, 13, 7};
    bit         stream_done;

    initial begin
        setv( 0, 1'b0, 32'hFF800000, 32'h00000000, 32'hFF800001, 1, 1, 0);
        setv( 1, 1'b1, 32'h3F800000, 32'h80000000, 32'hFF800000, 1, 0, 1);
        setv( 2, 1'b0, 32'h3F800000, 32'h40000000, 32'h00000000, 0, 0, 0);
        setv( 3, 1'b0, 32'h7FC00000, 32'h3F800000, 32'h7F800001, 1, 0, 0);
        setv( 4, 1'b1, 32'h00000000, 32'h00000000, 32'h7F800001, 1, 1, 0);
        setv( 5, 1'b1, 32'h7F800000, 32'hFF800000, 32'hFF800001, 1, 1, 0);
        setv( 6, 1'b1, 32'hFF800000, 32'h40000000, 32'hFF800000, 1, 0, 0);
        setv( 7, 1'b1, 32'h40000000, 32'h7F800000, 32'h00000000, 1, 0, 0);
        setv( 8, 1'b1, 32'h80000000, 32'h40000000, 32'h80000000, 1, 0, 0);
        setv( 9, 1'b0, 32'h7F800000, 32'hC0000000, 32'hFF800000, 1, 0, 0);
        setv(10, 1'b0, 32'h80000000, 32'h3F800000, 32'h80000000, 1, 0, 0);
        setv(11, 1'b1, 32'hBF800000, 32'h40000000, 32'h80000000, 0, 0, 0);
`ifdef FP_SPECIAL_DENORM_FLUSH_EN
        setv(12, 1'b0, 32'h00000001, 32'h7F800000, 32'h7F800001, 1, 1, 0);
        setv(13, 1'b1, 32'h00000001, 32'h00000000, 32'h7F800001, 1, 1, 0);
`else
        setv(12, 1'b0, 32'h00000001, 32'h7F800000, 32'h7F800000, 1, 0, 0);
        setv(13, 1'b1, 32'h00000001, 32'h00000000, 32'h7F800000, 1, 0, 1);
`endif
        setv(14, 1'b1, 32'h7F800000, 32'h7FC00000, 32'h7F800001, 1, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", special_result, 32'd0);
        chk("rst_is_special", {31'b0, is_special}, 32'd0);
        chk("rst_flags", {30'b0, flag_invalid, flag_dbz}, 32'd0);
        chk("rst_sticky", {30'b0, sticky_invalid, sticky_dbz}, 32'd0);
        rst = 1'b0;

        // Latency: Inf x 0, out_valid exactly two cycles after the input cycle
        @(posedge clk); #1;
        in_valid = 1'b1; op_div = v_op[0]; a = v_a[0]; b = v_b[0];
        @(posedge clk);
        q.push_back(v_exp[0]);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("latency_c1_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_c2_out_valid", {31'b0, out_valid}, 32'd1);
        drain();
        chk("sticky_invalid_set", {31'b0, sticky_invalid}, 32'd1);

        // Divide by zero, then a lone clear
        send(1);
        drain();
        chk("sticky_dbz_set", {31'b0, sticky_dbz}, 32'd1);
        clr_pulse();
        chk("sticky_dbz_cleared", {31'b0, sticky_dbz}, 32'd0);
        chk("sticky_invalid_cleared", {31'b0, sticky_invalid}, 32'd0);

        // All directed vectors back-to-back at full throughput
        for (int i = 2; i < 15; i++) send(i);
        drain();

        // Mixed stream with out_ready toggling 1,0,0,1
        stream_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(stream_ids[k]);
                stream_done = 1'b1;
            end
            begin
                int c = 0;
                while (!stream_done) begin
                    out_ready = pat[c % 4];
                    c++;
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Clear coinciding with an invalid handshake: the set wins, dbz clears
        clr_pulse();
        send(1);
        drain();
        chk("pre_coincide_dbz", {31'b0, sticky_dbz}, 32'd1);
        chk("pre_coincide_invalid", {31'b0, sticky_invalid}, 32'd0);
        send(4);
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 10);
            if (!out_valid) chk("coincide_timeout", 32'd1, 32'd0);
        end
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("coincide_sticky_invalid", {31'b0, sticky_invalid}, 32'd1);
        chk("coincide_sticky_dbz", {31'b0, sticky_dbz}, 32'd0);

        // Fill both stages while stalled, then reset mid-operation
        out_ready = 1'b0;
        send(0);
        send(5);
        @(negedge clk);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sticky", {30'b0, sticky_invalid, sticky_dbz}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_flags", {30'b0, flag_invalid, flag_dbz}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/fp_special_case_unit.md
# fp_special_case_unit

Pipelined, parametrised IEEE-754 special-case stage for the floating-point datapath. It classifies two raw operands and resolves every special outcome for multiply or divide. Outputs are the special result, a bypass flag, and sticky exception flags. It sits in parallel with the mantissa/exponent datapath, behind a valid/ready handshake, and replaces the single-precision combinational multiply-only handler.

## Interface
- EXP_W, 8, exponent width (≥2)
- MAN_W, 23, fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit accepts operands this cycle
- op_div  in  1  0 = multiply, 1 = divide (a / b)
- a, b  in  W  raw IEEE operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- special_result  out  W  resolved result (meaningful when is_special=1)
- is_special  out  1  result bypasses the arithmetic datapath
- flag_invalid, flag_dbz  out  1  per-result invalid / divide-by-zero
- sticky_invalid, sticky_dbz  out  1  accumulated flags
- flags_clr  in  1  clear sticky flags

## Operation
- Classification:
  - exp all-ones with frac≠0 → NaN; frac=0 → Inf.
  - exp=0 with frac=0 → zero.
  - Everything else is finite.
- res_sign = sign(a) XOR sign(b), used for every output, including NaN.
- Canonical NaN = {res_sign, all-ones exp, fraction = 1 (LSB only)}. Inf = {res_sign, all-ones, 0}. Zero = {res_sign, 0, 0}.
- Multiply, first match wins:
  1. Any NaN → NaN.
  2. Inf×0 → NaN, invalid.
  3. Any Inf → Inf.
  4. Any zero → zero.
- Divide, first match wins:
  1. Any NaN → NaN.
  2. 0/0 or Inf/Inf → NaN, invalid.
  3. Inf/x → Inf.
  4. x/0 (x finite, nonzero) → Inf, dbz.
  5. x/Inf or 0/x → zero.
- Not special: is_special=0, special_result={res_sign, 0...0}, flags 0.
- Pipeline stage S1 registers the classification bits, sign and op_div. Stage S2 registers the result and flags.
- Each stage holds a valid bit. Stages advance as an elastic pipeline:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational)
- Sticky update occurs on the output handshake (out_valid & out_ready):
  - sticky <= (flags_clr ? 0 : sticky) | (handshake ? flag : 0).
  - A set in the same cycle as a clear wins.

## Timing
- Reset: all valid bits 0, out_valid=0, in_ready=1, special_result=0, is_special=0, all flags and sticky flags 0.
- Latency: 2 cycles from input handshake to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- Holding outputs:
  - With out_valid=1 and out_ready=0, outputs and flags stay stable.
  - S1 still fills if empty. in_ready drops only when both stages are full.
- Simultaneous input and output handshakes with full stages: both stages shift, and no bubble or loss occurs.
- Inputs are sampled only when in_valid & in_ready. Operands offered while in_ready=0 are ignored.
- Reset asserted mid-operation immediately flushes both stages and sticky flags. There is no partial output.
- No combinational path from a/b to outputs. out_ready→in_ready is the only combinational path.

## Configuration
- FP_SPECIAL_DENORM_FLUSH_EN
  - Defined: exp=0 with frac≠0 (subnormal) is classified as zero, including for Inf×0, 0/0 and x/0 rules.
  - Undefined: subnormals are finite nonzero.

## Test plan
- Multiply, 0xFF800000 × 0x00000000 → special_result 0xFF800001, is_special=1, flag_invalid=1, out_valid exactly 2 cycles after input.
- Divide, 0x3F800000 / 0x80000000 → 0xFF800000, flag_dbz=1. Then apply flags_clr alone → sticky_dbz=0.
- Multiply, 0x3F800000 × 0x40000000 → is_special=0, special_result 0x00000000, flags 0.
- Back-to-back stream of 8 mixed ops with out_ready toggling 1,0,0,1:
  - in_ready deasserts only with both stages full.
  - Results arrive in order with none dropped or duplicated.
  - Outputs stay stable while stalled.
- flags_clr coinciding with an invalid result handshake → sticky_invalid=1 afterwards. Assert rst mid-stream → out_valid=0 and sticky flags=0 immediately.
- Multiply, 0x00000001 × 0x7F800000:
  - Macro defined → 0x7F800001, invalid.
  - Macro undefined → 0x7F800000, no flag.
